credit_ledger: RTL and testbench
================================

CREDIT_LEDGER -- requirements
Module: credit_ledger

Interface
- REQ-001 Parameter NCH, default 3: number of coin channels (quarter, dime, nickel).
- REQ-002 Parameter W, default 7: credit and price width in bits.
- REQ-003 Parameter CMAX, default 100: credit ceiling in cents, CMAX < 2^W.
- REQ-004 clk  in  1  clock; all state updates on rising edge.
- REQ-005 reset  in  1  asynchronous, active-low reset; the block is in reset while low.
- REQ-006 coin_vld  in  NCH  per-channel coin-accepted strobe, one cycle per coin.
- REQ-007 coin_val  in  NCH*W  packed per-channel coin values; channel i occupies bits [i*W +: W].
- REQ-008 buy_req  in  1  purchase request level, held until buy_ack or buy_nak.
- REQ-009 buy_price  in  W  price of the item, stable while buy_req is high.
- REQ-010 refund_req  in  1  change-return request, one-cycle pulse.
- REQ-011 credit  out  W  current registered credit.
- REQ-012 buy_ack / buy_nak  out  1 each  one-cycle purchase grant or refusal.
- REQ-013 change_out  out  W  refunded amount, valid while change_vld is high.
- REQ-014 change_vld  out  1  one-cycle refund strobe.
- REQ-015 ovf  out  1  sticky flag: a coin was clipped at CMAX.

Function
- REQ-016 FSM states: IDLE, DEBIT, HOLD, REFUND; encoding is free.
- REQ-017 Each cycle, coin_in = sum of coin_val[i] over all channels with coin_vld[i]=1, computed at width W+$clog2(NCH+1) with no truncation.
- REQ-018 Coins are accumulated in every state, including the REFUND cycle.
- REQ-019 IDLE, refund_req=1 -> REFUND; refund has priority over a simultaneous buy_req.
- REQ-020 IDLE, buy_req=1, refund_req=0 -> DEBIT.
- REQ-021 DEBIT: compare the registered credit (excluding this cycle's coin_in) with buy_price.
- REQ-022 DEBIT, credit >= buy_price: pulse buy_ack; next credit = credit - buy_price + coin_in.
- REQ-023 DEBIT, credit < buy_price: pulse buy_nak; credit += coin_in.
- REQ-024 DEBIT -> HOLD in both cases.
- REQ-025 HOLD -> IDLE when buy_req=0; refund_req in HOLD is ignored.
- REQ-026 Purchase latency: ack/nak asserted exactly 1 cycle after buy_req is sampled in IDLE.
- REQ-027 REFUND: change_out = credit, change_vld=1 for one cycle; next credit = coin_in, subject to REQ-029; ovf cleared; -> IDLE.
- REQ-028 Zero-credit refund is legal: change_vld=1 with change_out=0.
- REQ-029 Credit update limit follows REQ-035/REQ-036.
- REQ-030 change_out = 0 whenever change_vld = 0.

Reset
- REQ-031 While reset is low: state=IDLE, credit=0, ovf=0, buy_ack=0, buy_nak=0, change_vld=0, change_out=0, asynchronously.
- REQ-032 Reset mid-DEBIT or mid-REFUND aborts the transaction: no ack, nak or change pulse is emitted and credit is lost.
- REQ-033 First state update occurs on the first rising clk edge after reset goes high.
- REQ-034 Coins presented during reset or on the release edge are not counted.

Configuration
- REQ-035 With CREDIT_SAT_EN defined: any credit result > CMAX is clamped to CMAX and ovf is set, sticky until REFUND or reset.
- REQ-036 Without CREDIT_SAT_EN: the credit result wraps modulo 2^W, CMAX is unused, and ovf is tied to 0.

Verification
- REQ-037 Defaults, CREDIT_SAT_EN defined; coins 25/10/5 all valid in one cycle -> credit=40 next cycle.
- REQ-038 credit=40, buy_req with price=35 -> buy_ack 1 cycle later, credit=5, state HOLD until buy_req drops.
- REQ-039 credit=5, buy_req with price=10, plus a 5 coin in the DEBIT cycle -> buy_nak, credit=10.
- REQ-040 credit=90, quarter+dime inserted -> credit=100, ovf=1; refund_req -> change_out=100, change_vld 1 cycle, credit=0, ovf=0.
- REQ-041 refund_req and buy_req both high in IDLE -> REFUND taken; neither buy_ack nor buy_nak issued until a new request is sampled in IDLE.
- REQ-042 CREDIT_SAT_EN undefined, credit=120, quarter inserted -> credit=17, ovf=0; reset pulsed low mid-DEBIT -> all outputs 0 immediately, no ack.

Source files
------------

// File: rtl/credit_ledger.sv
// credit_ledger: coin credit accumulator with purchase debit and refund.
// Optional feature macro: CREDIT_SAT_EN -- when defined, credit results above
// CMAX clamp to CMAX and set the sticky ovf flag; otherwise credit wraps
// modulo 2^W and ovf is held at 0.
module credit_ledger #(
    parameter int NCH  = 3,
    parameter int W    = 7,
    parameter int CMAX = 100
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NCH-1:0]   coin_vld,
    input  logic [NCH*W-1:0] coin_val,
    input  logic             buy_req,
    input  logic [W-1:0]     buy_price,
    input  logic             refund_req,
    output logic [W-1:0]     credit,
    output logic             buy_ack,
    output logic             buy_nak,
    output logic [W-1:0]     change_out,
    output logic             change_vld,
    output logic             ovf
);

    // Sum width wide enough to add every channel plus the held credit.
    localparam int SW = W + $clog2(NCH + 1);

    // The ceiling must be representable in the credit register.
    if (CMAX >= (2 ** W)) begin : g_cmax_chk
        $error("credit_ledger: CMAX must be below 2^W");
    end

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DEBIT  = 2'd1,
        S_HOLD   = 2'd2,
        S_REFUND = 2'd3
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [W-1:0]   r_credit;
    logic [SW-1:0]  w_coin_in;
    logic [SW-1:0]  w_credit_ext;
    logic [SW-1:0]  w_price_ext;
    logic           w_afford;
    logic [SW-1:0]  w_raw_nxt;
    logic [W-1:0]   w_credit_nxt;
    logic           w_clip;

    // Limit an unbounded credit result to the register width.
    function automatic logic [W:0] limit_credit(input logic [SW-1:0] raw);
        logic [W:0] res;
`ifdef CREDIT_SAT_EN
        if (raw > SW'(CMAX)) begin
            res = {1'b1, W'(CMAX)};
        end else begin
            res = {1'b0, raw[W-1:0]};
        end
`else
        res = {1'b0, raw[W-1:0]};
`endif
        return res;
    endfunction

    assign w_credit_ext = {{(SW-W){1'b0}}, r_credit};
    assign w_price_ext  = {{(SW-W){1'b0}}, buy_price};
    // Affordability uses the held credit only; this cycle's coins do not count.
    assign w_afford     = (r_credit >= buy_price);

    // Sum all coins accepted this cycle without truncation.
    always_comb begin
        w_coin_in = '0;
        for (int i = 0; i < NCH; i++) begin
            if (coin_vld[i]) begin
                w_coin_in = w_coin_in + {{(SW-W){1'b0}}, coin_val[i*W +: W]};
            end
        end
    end

    // Unbounded next credit: coins are added in every state.
    always_comb begin
        w_raw_nxt = w_credit_ext + w_coin_in;
        case (r_state)
            S_DEBIT: begin
                if (w_afford) begin
                    w_raw_nxt = w_credit_ext - w_price_ext + w_coin_in;
                end
            end
            S_REFUND: begin
                w_raw_nxt = w_coin_in;
            end
            default: begin
                w_raw_nxt = w_credit_ext + w_coin_in;
            end
        endcase
        {w_clip, w_credit_nxt} = limit_credit(w_raw_nxt);
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; refund wins over a simultaneous purchase in IDLE.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (refund_req) begin
                    w_state_nxt = S_REFUND;
                end else if (buy_req) begin
                    w_state_nxt = S_DEBIT;
                end
            end
            S_DEBIT:  w_state_nxt = S_HOLD;
            S_HOLD: begin
                if (!buy_req) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_REFUND: w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Output decode: strobes are pure functions of state so reset clears them at once.
    always_comb begin
        buy_ack    = 1'b0;
        buy_nak    = 1'b0;
        change_vld = 1'b0;
        change_out = '0;
        case (r_state)
            S_DEBIT: begin
                buy_ack = w_afford;
                buy_nak = !w_afford;
            end
            S_REFUND: begin
                change_vld = 1'b1;
                change_out = r_credit;
            end
            default: begin
                buy_ack = 1'b0;
            end
        endcase
    end

    // Credit register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_credit <= '0;
        end else begin
            r_credit <= w_credit_nxt;
        end
    end

    assign credit = r_credit;

`ifdef CREDIT_SAT_EN
    logic r_ovf;

    // Sticky clip flag, restarted by a refund.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ovf <= 1'b0;
        end else if (r_state == S_REFUND) begin
            r_ovf <= w_clip;
        end else begin
            r_ovf <= r_ovf | w_clip;
        end
    end

    assign ovf = r_ovf;
`else
    logic w_unused_clip;
    assign w_unused_clip = w_clip;
    assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_credit_ledger.sv
// Directed bench for credit_ledger (defaults NCH=3, W=7, CMAX=100).
module tb_credit_ledger;

    localparam int NCH = 3;
    localparam int W   = 7;

    logic             clk;
    logic             reset;
    logic [NCH-1:0]   coin_vld;
    logic [NCH*W-1:0] coin_val;
    logic             buy_req;
    logic [W-1:0]     buy_price;
    logic             refund_req;
    logic [W-1:0]     credit;
    logic             buy_ack;
    logic             buy_nak;
    logic [W-1:0]     change_out;
    logic             change_vld;
    logic             ovf;

    int n_chk;
    int n_err;

    credit_ledger #(.NCH(NCH), .W(W), .CMAX(100)) dut (
        .clk        (clk),
        .reset      (reset),
        .coin_vld   (coin_vld),
        .coin_val   (coin_val),
        .buy_req    (buy_req),
        .buy_price  (buy_price),
        .refund_req (refund_req),
        .credit     (credit),
        .buy_ack    (buy_ack),
        .buy_nak    (buy_nak),
        .change_out (change_out),
        .change_vld (change_vld),
        .ovf        (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are then sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic coins(input logic q, input logic d, input logic n);
        coin_vld = {n, d, q};
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        n_chk      = 0;
        n_err      = 0;
        reset      = 1'b0;
        coin_vld   = '0;
        coin_val   = {7'd5, 7'd10, 7'd25};
        buy_req    = 1'b0;
        buy_price  = '0;
        refund_req = 1'b0;

        // Coins during reset are discarded.
        coins(1, 1, 1);
        tick();
        chk("rst_credit", credit, 0);
        chk("rst_ack", buy_ack, 0);
        chk("rst_nak", buy_nak, 0);
        chk("rst_cvld", change_vld, 0);
        chk("rst_cout", change_out, 0);
        chk("rst_ovf", ovf, 0);
        coins(0, 0, 0);
        #3;
        reset = 1'b1;

        // All three coins in one cycle.
        tick();
        coins(1, 1, 1);
        tick();
        coins(0, 0, 0);
        chk("sum40", credit, 40);

        // Affordable purchase.
        buy_req   = 1'b1;
        buy_price = 7'd35;
        tick();
        chk("buy35_ack", buy_ack, 1);
        chk("buy35_nak", buy_nak, 0);
        tick();
        chk("buy35_credit", credit, 5);
        chk("hold_ack", buy_ack, 0);
        tick();
        chk("hold_ack2", buy_ack, 0);
        buy_req = 1'b0;
        tick();

        // Unaffordable purchase with a nickel arriving in the DEBIT cycle.
        buy_req   = 1'b1;
        buy_price = 7'd10;
        tick();
        coins(0, 0, 1);
        chk("buy10_nak", buy_nak, 1);
        chk("buy10_ack", buy_ack, 0);
        tick();
        coins(0, 0, 0);
        chk("nak_credit", credit, 10);
        buy_req = 1'b0;
        tick();

        // Build to 90 then add quarter + dime.
        coins(1, 0, 0);
        tick(); tick(); tick();
        coins(0, 0, 1);
        tick();
        coins(0, 0, 0);
        chk("credit90", credit, 90);
        coins(1, 1, 0);
        tick();
        coins(0, 0, 0);
`ifdef CREDIT_SAT_EN
        chk("clip_credit", credit, 100);
        chk("clip_ovf", ovf, 1);
`else
        chk("noclip_credit", credit, 125);
        chk("noclip_ovf", ovf, 0);
`endif
        refund_req = 1'b1;
        tick();
        refund_req = 1'b0;
        chk("ref_vld", change_vld, 1);
`ifdef CREDIT_SAT_EN
        chk("ref_out", change_out, 100);
`else
        chk("ref_out", change_out, 125);
`endif
        tick();
        chk("ref_credit", credit, 0);
        chk("ref_ovf", ovf, 0);
        chk("ref_vld_end", change_vld, 0);
        chk("ref_out_end", change_out, 0);

        // Refund beats a simultaneous purchase request.
        coins(0, 1, 0);
        tick();
        coins(0, 0, 0);
        refund_req = 1'b1;
        buy_req    = 1'b1;
        buy_price  = 7'd5;
        tick();
        refund_req = 1'b0;
        buy_req    = 1'b0;
        chk("pri_vld", change_vld, 1);
        chk("pri_out", change_out, 10);
        chk("pri_ack", buy_ack, 0);
        chk("pri_nak", buy_nak, 0);
        tick();
        chk("pri_ack2", buy_ack, 0);
        chk("pri_nak2", buy_nak, 0);

        // Zero-credit refund.
        refund_req = 1'b1;
        tick();
        refund_req = 1'b0;
        chk("zref_vld", change_vld, 1);
        chk("zref_out", change_out, 0);
        tick();

        // Approach 120 in steps of 30, then add a quarter.
        coins(1, 0, 1);
        tick(); tick(); tick(); tick();
        coins(1, 0, 0);
`ifdef CREDIT_SAT_EN
        chk("c120", credit, 100);
        chk("c120_ovf", ovf, 1);
`else
        chk("c120", credit, 120);
`endif
        tick();
        coins(0, 0, 0);
`ifdef CREDIT_SAT_EN
        chk("wrap_credit", credit, 100);
        chk("wrap_ovf", ovf, 1);
`else
        chk("wrap_credit", credit, 17);
        chk("wrap_ovf", ovf, 0);
`endif

        // Reset in the middle of DEBIT.
        buy_req   = 1'b1;
        buy_price = 7'd5;
        tick();
        chk("pre_rst_ack", buy_ack, 1);
        #2;
        reset = 1'b0;
        #1;
        chk("mid_rst_ack", buy_ack, 0);
        chk("mid_rst_nak", buy_nak, 0);
        chk("mid_rst_credit", credit, 0);
        chk("mid_rst_ovf", ovf, 0);
        buy_req = 1'b0;
        #3;
        reset = 1'b1;
        tick();
        chk("post_rst_ack", buy_ack, 0);
        chk("post_rst_credit", credit, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
